// File: rtl/enigma_pkg.sv
// Shared types, defaults and reset wiring for the Enigma rotor stage.
package enigma_pkg;

  localparam int ALPHA_DEFAULT = 32'sd26;
  localparam int NOTCH_DEFAULT = 32'sd21;
  localparam int W_DEFAULT     = 32'sd5;

  typedef logic [W_DEFAULT-1:0] letter_t;

  localparam letter_t DEFAULT_WIRING [ALPHA_DEFAULT] = '{
    5'd14, 5'd8,  5'd24, 5'd13, 5'd16, 5'd18, 5'd20, 5'd6,  5'd19,
    5'd22, 5'd25, 5'd1,  5'd10, 5'd17, 5'd2,  5'd23, 5'd5,  5'd3,
    5'd4,  5'd9,  5'd26, 5'd12, 5'd11, 5'd7,  5'd21, 5'd15
  };

  // Positions beyond the stock 26-letter wheel fall back to identity.
  function automatic int default_map(input int idx);
    int r;
    if ((idx >= 32'sd0) && (idx < ALPHA_DEFAULT)) begin
      r = int'(DEFAULT_WIRING[idx[4:0]]);
    end else begin
      r = idx + 32'sd1;
    end
    return r;
  endfunction

  function automatic int default_inv(input int idx, input int alpha);
    int r;
    r = idx + 32'sd1;
    for (int a = 0; a < alpha; a++) begin
      if (default_map(a) == idx + 32'sd1) begin
        r = a + 32'sd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/enigma_rotor_stage_if.sv
// Lookup request/response bundle of the Enigma rotor stage.
interface enigma_rotor_stage_if
  import enigma_pkg::*;
#(
  parameter int W = W_DEFAULT
) ();

  logic         in_valid;
  logic [W-1:0] in_letter;
  logic         in_dir;
  logic         out_valid;
  logic [W-1:0] out_letter;
  logic         out_err;

  modport master (
    output in_valid, in_letter, in_dir,
    input  out_valid, out_letter, out_err
  );

  modport slave (
    input  in_valid, in_letter, in_dir,
    output out_valid, out_letter, out_err
  );

endinterface

// File: rtl/rotor_wiring_ram.sv
// ALPHA x W wiring table: reset preload (forward or inverse wiring), one write port, async read.
module rotor_wiring_ram
  import enigma_pkg::*;
#(
  parameter int ALPHA   = ALPHA_DEFAULT,
  parameter int W       = W_DEFAULT,
  parameter bit INVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [W-1:0] raddr,
  output logic [W-1:0] rdata
);

  localparam logic [W:0] ALPHA_X = (W+1)'(ALPHA);

  logic [W-1:0] mem_r [ALPHA];

  // Table storage: reloads the default wiring on reset, otherwise takes writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ALPHA; i++) begin
        mem_r[i] <= W'(INVERSE ? default_inv(i, ALPHA) : default_map(i));
      end
    end else if (we && ({1'b0, waddr} < ALPHA_X)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  always_comb begin
    if ({1'b0, raddr} < ALPHA_X) begin
      rdata = mem_r[raddr];
    end else begin
      rdata = {W{1'b0}};
    end
  end

endmodule

// File: rtl/enigma_rotor_stage.sv
// Enigma rotor stage: stepping position with notch carry, ring offset, 1-cycle registered lookup.
// Build with ENIGMA_ROTOR_REVERSE_EN defined to add the inverse table and reverse path.
module enigma_rotor_stage
  import enigma_pkg::*;
#(
  parameter int ALPHA = ALPHA_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int NOTCH = NOTCH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  enigma_rotor_stage_if.slave  lk,
  input  logic                 step,
  output logic                 carry_out,
  input  logic                 pos_load,
  input  logic [W-1:0]         pos_data,
  input  logic [W-1:0]         ring,
  input  logic                 cfg_we,
  input  logic [W-1:0]         cfg_addr,
  input  logic [W-1:0]         cfg_data,
  output logic [W-1:0]         pos
);

  localparam logic [W:0]   ALPHA_X   = (W+1)'(ALPHA);
  localparam logic [W-1:0] LAST_POS  = W'(ALPHA - 1);
  localparam logic [W-1:0] NOTCH_POS = W'(NOTCH);
  localparam logic [W-1:0] ONE       = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO      = {W{1'b0}};

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= ALPHA_X) begin
      s = s - ALPHA_X;
    end else begin
      s = s;
    end
    return s[W-1:0];
  endfunction

  // A borrow out of the W-bit difference shows up in bit W.
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) begin
      d = d + ALPHA_X;
    end else begin
      d = d;
    end
    return d[W-1:0];
  endfunction

  logic [W-1:0] idx_s;
  logic [W-1:0] tab_s;
  logic [W-1:0] map_s;
  logic [W-1:0] res_s;
  logic [W-1:0] fwd_rdata_s;
  logic         letter_ok_s;
  logic         cfg_ok_s;

  // Undo position/ring offset into the table, then re-apply it to the mapped letter.
  always_comb begin
    letter_ok_s = (lk.in_letter != ZERO) && ({1'b0, lk.in_letter} <= ALPHA_X);
    idx_s       = mod_sub(mod_add(lk.in_letter - ONE, pos), ring);
    map_s       = tab_s - ONE;
    res_s       = mod_add(mod_sub(map_s, pos), ring) + ONE;
  end

  // Out-of-range writes are dropped so both tables stay within 1..ALPHA.
  always_comb begin
    cfg_ok_s = cfg_we
             && ({1'b0, cfg_addr} < ALPHA_X)
             && (cfg_data != ZERO)
             && ({1'b0, cfg_data} <= ALPHA_X);
  end

  rotor_wiring_ram #(
    .ALPHA   (ALPHA),
    .W       (W),
    .INVERSE (1'b0)
  ) u_fwd_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_ok_s),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_s),
    .rdata (fwd_rdata_s)
  );

`ifdef ENIGMA_ROTOR_REVERSE_EN
  logic [W-1:0] inv_rdata_s;

  rotor_wiring_ram #(
    .ALPHA   (ALPHA),
    .W       (W),
    .INVERSE (1'b1)
  ) u_inv_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_ok_s),
    .waddr (cfg_data - ONE),
    .wdata (cfg_addr + ONE),
    .raddr (idx_s),
    .rdata (inv_rdata_s)
  );

  // Table select by lookup direction.
  always_comb begin
    if (lk.in_dir) begin
      tab_s = inv_rdata_s;
    end else begin
      tab_s = fwd_rdata_s;
    end
  end
`else
  logic unused_dir_s;
  assign unused_dir_s = lk.in_dir;
  assign tab_s        = fwd_rdata_s;
`endif

  // Lookup result register; letter and error hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk.out_valid  <= 1'b0;
      lk.out_letter <= ZERO;
      lk.out_err    <= 1'b0;
    end else begin
      lk.out_valid <= lk.in_valid;
      if (lk.in_valid) begin
        lk.out_letter <= letter_ok_s ? res_s : ZERO;
        lk.out_err    <= ~letter_ok_s;
      end else begin
        lk.out_letter <= lk.out_letter;
        lk.out_err    <= lk.out_err;
      end
    end
  end

  // Rotor position and notch carry; a preset wins over a step and never carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos       <= ZERO;
      carry_out <= 1'b0;
    end else if (pos_load) begin
      if ({1'b0, pos_data} < ALPHA_X) begin
        pos <= pos_data;
      end else begin
        pos <= pos;
      end
      carry_out <= 1'b0;
    end else if (step) begin
      pos       <= (pos == LAST_POS) ? ZERO : pos + ONE;
      carry_out <= (pos == NOTCH_POS);
    end else begin
      pos       <= pos;
      carry_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Randomized bench for enigma_rotor_stage against an arithmetic rotor model.
module tb_enigma_rotor_stage;

  localparam int ALPHA = 26;
  localparam int W     = 5;
  localparam int NOTCH = 21;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         step;
  logic         pos_load;
  logic [W-1:0] pos_data;
  logic [W-1:0] ring;
  logic         cfg_we;
  logic [W-1:0] cfg_addr;
  logic [W-1:0] cfg_data;
  logic         carry_out;
  logic [W-1:0] pos;

  enigma_rotor_stage_if #(.W(W)) lk ();

  enigma_rotor_stage #(
    .ALPHA (ALPHA),
    .W     (W),
    .NOTCH (NOTCH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk        (lk),
    .step      (step),
    .carry_out (carry_out),
    .pos_load  (pos_load),
    .pos_data  (pos_data),
    .ring      (ring),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int wiring [ALPHA] = '{14, 8, 24, 13, 16, 18, 20, 6, 19, 22, 25, 1, 10,
                         17, 2, 23, 5, 3, 4, 9, 26, 12, 11, 7, 21, 15};
  int m_t    [ALPHA];
  int m_tinv [ALPHA];
  int m_pos;
  int exp_valid;
  int exp_letter;
  int exp_err;
  int exp_carry;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos      = 0;
    exp_valid  = 0;
    exp_letter = 0;
    exp_err    = 0;
    exp_carry  = 0;
    for (int i = 0; i < ALPHA; i++) m_t[i] = wiring[i];
    for (int i = 0; i < ALPHA; i++) m_tinv[m_t[i] - 1] = i + 1;
  endtask

  function automatic int wrap(input int v);
    return ((v % ALPHA) + ALPHA) % ALPHA;
  endfunction

  function automatic int ref_map(input int l, input int rev);
    int idx;
    int m;
    idx = wrap(l - 1 + m_pos - int'(ring));
    m   = rev ? m_tinv[idx] : m_t[idx];
    return wrap(m - 1 - m_pos + int'(ring)) + 1;
  endfunction

  // Advance the model by one clock using the inputs the DUT saw at that edge.
  task automatic model_update();
    int l;
    int rev;
    int a;
    int d;
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef ENIGMA_ROTOR_REVERSE_EN
    rev = int'(lk.in_dir);
`else
    rev = 0;
`endif
    exp_valid = int'(lk.in_valid);
    if (lk.in_valid) begin
      l = int'(lk.in_letter);
      if (l < 1 || l > ALPHA) begin
        exp_letter = 0;
        exp_err    = 1;
      end else begin
        exp_letter = ref_map(l, rev);
        exp_err    = 0;
      end
    end
    if (pos_load) begin
      exp_carry = 0;
      if (int'(pos_data) < ALPHA) m_pos = int'(pos_data);
    end else if (step) begin
      exp_carry = (m_pos == NOTCH) ? 1 : 0;
      m_pos     = (m_pos + 1) % ALPHA;
    end else begin
      exp_carry = 0;
    end
    a = int'(cfg_addr);
    d = int'(cfg_data);
    if (cfg_we && a < ALPHA && d >= 1 && d <= ALPHA) begin
      m_t[a]        = d;
      m_tinv[d - 1] = a + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    lk.in_valid = 1'b0;
    step        = 1'b0;
    pos_load    = 1'b0;
    cfg_we      = 1'b0;
  endtask

  task automatic lookup(input int l, input int dir);
    lk.in_valid  = 1'b1;
    lk.in_letter = W'(l);
    lk.in_dir    = dir[0];
    tick();
    idle();
  endtask

  // Every negedge: DUT outputs against the model.
  always @(negedge clk) begin
    chk("out_valid", int'(lk.out_valid), exp_valid);
    chk("out_letter", int'(lk.out_letter), exp_letter);
    chk("out_err", int'(lk.out_err), exp_err);
    chk("pos", int'(pos), m_pos);
    chk("carry_out", int'(carry_out), exp_carry);
  end

  initial begin
    rst_n        = 1'b0;
    idle();
    lk.in_letter = '0;
    lk.in_dir    = 1'b0;
    pos_data     = '0;
    ring         = '0;
    cfg_addr     = '0;
    cfg_data     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("reset_valid", int'(lk.out_valid), 0);
    chk("reset_letter", int'(lk.out_letter), 0);
    chk("reset_pos", int'(pos), 0);
    chk("reset_carry", int'(carry_out), 0);

    lookup(1, 0);
    chk("lit_fwd_valid", int'(lk.out_valid), 1);
    chk("lit_fwd_a", int'(lk.out_letter), 14);
    chk("lit_model_a", exp_letter, 14);
    tick();
    chk("lit_valid_drop", int'(lk.out_valid), 0);
    chk("lit_letter_hold", int'(lk.out_letter), 14);

    step = 1'b1;
    tick();
    idle();
    lookup(1, 0);
    chk("lit_step_pos", int'(pos), 1);
    chk("lit_step_letter", int'(lk.out_letter), 7);
    chk("lit_model_step", exp_letter, 7);

    pos_load = 1'b1; pos_data = 5'd21; tick(); idle();
    step = 1'b1; tick(); idle();
    chk("lit_notch_pos", int'(pos), 22);
    chk("lit_notch_carry", int'(carry_out), 1);
    tick();
    chk("lit_carry_pulse", int'(carry_out), 0);
    pos_load = 1'b1; pos_data = 5'd25; tick(); idle();
    step = 1'b1; tick(); idle();
    chk("lit_wrap_pos", int'(pos), 0);
    chk("lit_wrap_carry", int'(carry_out), 0);

    lookup(0, 0);
    chk("lit_err0_letter", int'(lk.out_letter), 0);
    chk("lit_err0_err", int'(lk.out_err), 1);
    lookup(27, 0);
    chk("lit_err27_letter", int'(lk.out_letter), 0);
    chk("lit_err27_err", int'(lk.out_err), 1);

    lookup(14, 1);
`ifdef ENIGMA_ROTOR_REVERSE_EN
    chk("lit_rev", int'(lk.out_letter), 1);
`else
    chk("lit_dir_ignored", int'(lk.out_letter), 17);
`endif
    chk("lit_err_clear", int'(lk.out_err), 0);

    pos_load = 1'b1; pos_data = 5'd21; tick(); idle();
    step = 1'b1; pos_load = 1'b1; pos_data = 5'd5; tick(); idle();
    chk("lit_load_prio_pos", int'(pos), 5);
    chk("lit_load_prio_carry", int'(carry_out), 0);

    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 5'd5; tick(); idle();
    lookup(1, 0);
    pos_load = 1'b1; pos_data = 5'd9; tick(); idle();
    lk.in_valid  = 1'b1;
    lk.in_letter = 5'd3;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("lit_async_valid", int'(lk.out_valid), 0);
    chk("lit_async_pos", int'(pos), 0);
    chk("lit_async_letter", int'(lk.out_letter), 0);
    tick();
    idle();
    chk("lit_drop_valid", int'(lk.out_valid), 0);
    rst_n = 1'b1;
    lookup(1, 0);
    chk("lit_table_reload", int'(lk.out_letter), 14);

    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) ring = W'($urandom_range(0, ALPHA - 1));
      lk.in_valid  = 1'($urandom_range(0, 1));
      lk.in_letter = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 31))
                                                 : W'($urandom_range(1, ALPHA));
      lk.in_dir    = 1'($urandom_range(0, 1));
      step         = ($urandom_range(0, 2) == 0);
      pos_load     = ($urandom_range(0, 15) == 0);
      pos_data     = W'($urandom_range(0, ALPHA - 1));
      cfg_we       = ($urandom_range(0, 19) == 0);
      cfg_addr     = W'($urandom_range(0, 31));
      cfg_data     = W'($urandom_range(0, 31));
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
